// File: rtl/im_fetch_queue.sv
// Instruction ROM + prefetch queue of {pc, instr} entries; optional IM_RANGE_CHECK_EN turns out-of-range/misaligned fetches into fault entries.
// Latency: a fetch issued in cycle N is at the head in N+2; a redirect in cycle N presents its target at the head in N+2.
// Backpressure: out_ready=0 freezes the head; reads stop once queued + in-flight entries reach FIFO_DEPTH.
module im_fetch_queue #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
    parameter int          MEM_WORDS  = 4096,
    parameter int          FIFO_DEPTH = 4,
    parameter string       INIT_FILE  = "code.txt"
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [5:0]  out_op,
    output logic [5:0]  out_func,
    output logic [4:0]  out_rs,
    output logic [4:0]  out_rt,
    output logic [4:0]  out_rd,
    output logic [15:0] out_imm,
    output logic [25:0] out_index,
    output logic        out_fault
);

    localparam int          IW        = $clog2(MEM_WORDS);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          CW        = AW + 1;
    localparam logic [31:0] ROM_BYTES = 32'(MEM_WORDS) << 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    logic [31:0]   mem [MEM_WORDS];
    logic [31:0]   rom_dat;
    logic [31:0]   fetch_pc;
    logic [31:0]   rd_pc;
    logic [31:0]   rd_offset;
    logic [IW-1:0] rd_idx;
    logic          rd_fault;
    logic          issue;
    logic          launch;

    logic          inflight;
    logic [31:0]   inflight_pc;
    logic          inflight_fault;

    entry_t        fifo [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [CW-1:0] count_after_pop;
    logic          push;
    logic          pop;
    entry_t        push_ent;
    entry_t        head_next;
    entry_t        head_q;
    logic          unused_bits;

    // A redirect launches its target read in the same cycle so the target reaches the head two cycles later.
    assign rd_pc     = redirect ? redirect_pc : fetch_pc;
    assign rd_offset = rd_pc - BASE_ADDR;
    assign rd_idx    = rd_offset[IW+1:2];
    assign issue     = fetch_en && !redirect &&
                       (({1'b0, count} + {{CW{1'b0}}, inflight}) < (CW+1)'(FIFO_DEPTH));
    assign launch    = fetch_en && (redirect || issue);

`ifdef IM_RANGE_CHECK_EN
    assign rd_fault    = (rd_pc < BASE_ADDR) || (rd_offset >= ROM_BYTES) || (rd_pc[1:0] != 2'b00);
    assign out_fault   = head_q.fault;
    assign unused_bits = ^{rd_offset[31:IW+2], rd_offset[1:0]};
`else
    assign rd_fault    = 1'b0;
    assign out_fault   = 1'b0;
    assign unused_bits = ^{rd_offset[31:IW+2], rd_offset[1:0], head_q.fault, ROM_BYTES};
`endif

    always_ff @(posedge clk) begin
        if (launch && !rd_fault) rom_dat <= mem[rd_idx];
    end

    // Faulting fetches never touch the ROM and enter the queue as a nop.
    assign push_ent.pc    = inflight_pc;
    assign push_ent.instr = inflight_fault ? 32'h0 : rom_dat;
    assign push_ent.fault = inflight_fault;

    assign out_valid       = (count != '0);
    assign push            = inflight && !redirect;
    assign pop             = out_valid && out_ready && !redirect;
    assign count_after_pop = count - CW'(pop);
    assign count_next      = redirect ? '0 : count_after_pop + CW'(push);

    always_comb begin
        head_next = fifo[rd_ptr + AW'(pop)];
        if (count_after_pop == '0) head_next = push_ent;
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= push_ent;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc       <= BASE_ADDR;
            inflight       <= 1'b0;
            inflight_pc    <= '0;
            inflight_fault <= 1'b0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            head_q         <= '0;
        end else begin
            if (redirect) begin
                fetch_pc <= launch ? redirect_pc + 32'd4 : redirect_pc;
            end else if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            inflight <= launch;
            if (launch) begin
                inflight_pc    <= rd_pc;
                inflight_fault <= rd_fault;
            end

            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end

            count <= count_next;
            // Outputs only change when a new head exists; an empty queue keeps the last values.
            if (!redirect && count_next != '0) head_q <= head_next;
        end
    end

    assign out_pc    = head_q.pc;
    assign out_instr = head_q.instr;
    assign out_op    = head_q.instr[31:26];
    assign out_rs    = head_q.instr[25:21];
    assign out_rt    = head_q.instr[20:16];
    assign out_rd    = head_q.instr[15:11];
    assign out_func  = head_q.instr[5:0];
    assign out_imm   = head_q.instr[15:0];
    assign out_index = head_q.instr[25:0];

endmodule

// File: tb/tb_im_fetch_queue.sv
// Directed bench for im_fetch_queue with a 64-word ROM filled with a known pattern.
module tb_im_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [5:0]  out_op;
    logic [5:0]  out_func;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [15:0] out_imm;
    logic [25:0] out_index;
    logic        out_fault;

    int vectors = 0;
    int errors  = 0;

    im_fetch_queue #(
        .BASE_ADDR (32'h0000_3000),
        .MEM_WORDS (64),
        .FIFO_DEPTH(4),
        .INIT_FILE ("")
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_en   (fetch_en),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .out_op     (out_op),
        .out_func   (out_func),
        .out_rs     (out_rs),
        .out_rt     (out_rt),
        .out_rd     (out_rd),
        .out_imm    (out_imm),
        .out_index  (out_index),
        .out_fault  (out_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input int i);
        return 32'hA8C4_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        fetch_en    = 1'b0;
        out_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        for (int i = 0; i < 64; i++) dut.mem[i] = rom_word(i);

        tick;
        tick;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc",    out_pc,         32'h0);
        chk("rst_instr", out_instr,      32'h0);
        chk("rst_index", 32'(out_index), 32'h0);
        chk("rst_fault", 32'(out_fault), 32'd0);

        // Stream from reset release, then let fetch_en fall.
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        chk("s_c0_valid", 32'(out_valid), 32'd0);
        tick;
        chk("s_c1_valid", 32'(out_valid), 32'd0);
        tick;
        chk("s_c2_valid", 32'(out_valid), 32'd1);
        chk("s_c2_pc",    out_pc,         32'h3000);
        chk("s_c2_instr", out_instr,      rom_word(0));
        tick;
        chk("s_c3_pc",    out_pc,         32'h3004);
        chk("s_c3_instr", out_instr,      rom_word(1));
        tick;
        chk("s_c4_pc",    out_pc,         32'h3008);
        fetch_en = 1'b0;
        tick;
        chk("fe_c5_valid", 32'(out_valid), 32'd1);
        chk("fe_c5_pc",    out_pc,         32'h300C);
        tick;
        chk("fe_c6_valid", 32'(out_valid), 32'd0);
        tick;
        chk("fe_c7_valid", 32'(out_valid), 32'd0);
        chk("fe_c7_hold",  out_pc,         32'h300C);
        fetch_en = 1'b1;
        tick;
        chk("fe_c8_valid", 32'(out_valid), 32'd0);
        tick;
        chk("fe_c9_pc",    out_pc,         32'h3010);
        chk("fe_c9_instr", out_instr,      rom_word(4));

        // Asynchronous reset between edges, then fill the queue under backpressure.
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_pc",    out_pc,         32'h0);
        out_ready = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        tick;
        chk("bp_c2_valid", 32'(out_valid), 32'd1);
        chk("bp_c2_pc",    out_pc,         32'h3000);
        repeat (3) tick;
        chk("bp_c5_pc",    out_pc,         32'h3000);
        repeat (4) tick;
        chk("bp_c9_pc",    out_pc,         32'h3000);
        chk("bp_c9_instr", out_instr,      rom_word(0));
        tick;
        out_ready = 1'b1;
        chk("bp_c10_pc", out_pc, 32'h3000);
        for (int k = 1; k <= 4; k++) begin
            tick;
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk("drain_pc",    out_pc,         32'h3000 + 32'(4 * k));
            chk("drain_instr", out_instr,      rom_word(k));
        end

        // Redirect with a full queue while the head is being popped.
        #3 rst_n = 1'b0;
        out_ready = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        repeat (6) tick;
        chk("rd_c6_pc", out_pc, 32'h3000);
        redirect    = 1'b1;
        redirect_pc = 32'h3040;
        out_ready   = 1'b1;
        tick;
        redirect = 1'b0;
        chk("rd_c7_valid", 32'(out_valid), 32'd0);
        tick;
        chk("rd_c8_valid", 32'(out_valid), 32'd1);
        chk("rd_c8_pc",    out_pc,         32'h3040);
        chk("rd_c8_instr", out_instr,      32'hA8C4_1010);
        chk("dec_op",      32'(out_op),    32'h2A);
        chk("dec_rs",      32'(out_rs),    32'd6);
        chk("dec_rt",      32'(out_rt),    32'd4);
        chk("dec_rd",      32'(out_rd),    32'd2);
        chk("dec_func",    32'(out_func),  32'h10);
        chk("dec_imm",     32'(out_imm),   32'h1010);
        chk("dec_index",   32'(out_index), 32'h00C4_1010);
        tick;
        chk("rd_c9_pc",  out_pc, 32'h3044);
        tick;
        chk("rd_c10_pc", out_pc, 32'h3048);

        // Back-to-back redirects: only the second target may appear.
        redirect    = 1'b1;
        redirect_pc = 32'h3100;
        tick;
        chk("bb_c11_valid", 32'(out_valid), 32'd0);
        redirect_pc = 32'h3200;
        tick;
        redirect = 1'b0;
        chk("bb_c12_valid", 32'(out_valid), 32'd0);
        tick;
        chk("bb_c13_valid", 32'(out_valid), 32'd1);
        chk("bb_c13_pc",    out_pc,         32'h3200);
        chk("bb_c13_instr", out_instr,      rom_word(0));
        tick;
        chk("bb_c14_pc",    out_pc,         32'h3204);
        chk("bb_c14_instr", out_instr,      rom_word(1));

        // Last ROM word, then the word past the end.
        redirect    = 1'b1;
        redirect_pc = 32'h30FC;
        tick;
        redirect = 1'b0;
        chk("end_c15_valid", 32'(out_valid), 32'd0);
        tick;
        chk("end_c16_pc",    out_pc,         32'h30FC);
        chk("end_c16_instr", out_instr,      rom_word(63));
        chk("end_c16_fault", 32'(out_fault), 32'd0);
        tick;
        chk("end_c17_pc",    out_pc,         32'h3100);
`ifdef IM_RANGE_CHECK_EN
        chk("end_c17_instr", out_instr,      32'h0);
        chk("end_c17_fault", 32'(out_fault), 32'd1);
`else
        chk("end_c17_instr", out_instr,      rom_word(0));
        chk("end_c17_fault", 32'(out_fault), 32'd0);
`endif

        // Below the base, then misaligned.
        redirect    = 1'b1;
        redirect_pc = 32'h2FFC;
        tick;
        redirect = 1'b0;
        tick;
        chk("low_pc", out_pc, 32'h2FFC);
`ifdef IM_RANGE_CHECK_EN
        chk("low_instr", out_instr,      32'h0);
        chk("low_fault", 32'(out_fault), 32'd1);
`else
        chk("low_instr", out_instr,      rom_word(63));
        chk("low_fault", 32'(out_fault), 32'd0);
`endif
        redirect    = 1'b1;
        redirect_pc = 32'h3002;
        tick;
        redirect = 1'b0;
        tick;
        chk("mis_pc", out_pc, 32'h3002);
`ifdef IM_RANGE_CHECK_EN
        chk("mis_instr", out_instr,      32'h0);
        chk("mis_fault", 32'(out_fault), 32'd1);
`else
        chk("mis_instr", out_instr,      rom_word(0));
        chk("mis_fault", 32'(out_fault), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
